// File: rtl/reg_shift_pkg.sv
// Shared definitions for the universal shift register family.
// Mode encodings used by reg_shift_univ and anything driving its mode port.
package reg_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/reg_shift_univ_cnt_bits.sv
// cnt_bits_mod: counts shifted bits from 0 to WIDTH-1 and wraps.
// tc flags the last bit of a word so the parent can pulse word_valid.
module cnt_bits_mod #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(WIDTH - 1));

    // Bit counter: clear wins over inc; explicit wrap so non-power-of-two widths work
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/reg_shift_univ.sv
// reg_shift_univ: parametrised universal shift register (hold, shift right,
// shift left, parallel load) with synchronous clear and a word counter that
// pulses word_valid after every WIDTH counted shifts.
// Optional feature: define REG_SHIFT_PARITY_EN to add the parity output
// (XOR reduction of the register contents).
module reg_shift_univ
    import reg_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             entrada,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] salida,
    output logic             serial_out,
`ifdef REG_SHIFT_PARITY_EN
    output logic             parity,
`endif
    output logic             word_valid
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;
    logic             tc;
    logic             do_shift;
    logic             cnt_clear;

    // Only enabled shifts count; loads restart the word just like clear does
    assign do_shift  = !clear && enable && ((mode == MODE_SHR) || (mode == MODE_SHL));
    assign cnt_clear = clear || (enable && (mode == MODE_LOAD));

    cnt_bits_mod #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (do_shift),
        .count (count),
        .tc    (tc)
    );

    // Data register and word_valid pulse: clear beats enable, enable beats mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q          <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            q          <= '0;
            word_valid <= 1'b0;
        end else if (!enable) begin
            word_valid <= 1'b0;
        end else begin
            case (mode)
                MODE_SHR: begin
                    q          <= {entrada, q[WIDTH-1:1]};
                    word_valid <= tc;
                end
                MODE_SHL: begin
                    q          <= {q[WIDTH-2:0], entrada};
                    word_valid <= tc;
                end
                MODE_LOAD: begin
                    q          <= par_in;
                    word_valid <= 1'b0;
                end
                default: begin
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

    assign salida     = q;
    assign serial_out = (mode == MODE_SHL) ? q[WIDTH-1] : q[0];

`ifdef REG_SHIFT_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: tb/tb_reg_shift_univ.sv
// Self-checking bench for reg_shift_univ at WIDTH=4: hand sequences for reset,
// a table of directed vectors, then random stimulus against a reference model.
module tb_reg_shift_univ;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         enable;
    logic [1:0]   mode;
    logic         entrada;
    logic [W-1:0] par_in;
    logic [W-1:0] salida;
    logic         serial_out;
    logic         word_valid;
`ifdef REG_SHIFT_PARITY_EN
    logic         parity;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: register value and shifts since last clear/load
    int mq;
    int mshifts;
    int mwv;

    typedef struct {
        logic         clr;
        logic         en;
        logic [1:0]   m;
        logic         d;
        logic [W-1:0] p;
        logic         exp_so;
        logic [W-1:0] exp_q;
        logic         exp_wv;
    } vec_t;

    vec_t vecs[28];

    always #5 clk = ~clk;

    reg_shift_univ #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .enable     (enable),
        .mode       (mode),
        .entrada    (entrada),
        .par_in     (par_in),
        .salida     (salida),
        .serial_out (serial_out),
`ifdef REG_SHIFT_PARITY_EN
        .parity     (parity),
`endif
        .word_valid (word_valid)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive inputs, let combinational outputs settle, then return; caller clocks
    task automatic setInputs(input logic c, input logic e, input logic [1:0] m,
                             input logic d, input logic [W-1:0] p);
        clear   = c;
        enable  = e;
        mode    = m;
        entrada = d;
        par_in  = p;
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic e, input logic [1:0] m,
                                 input logic d, input logic [W-1:0] p);
        setInputs(c, e, m, d, p);
        @(posedge clk);
        #1;
    endtask

    // Model of one rising edge from the behavioural rules
    task automatic modelStep(input logic c, input logic e, input logic [1:0] m,
                             input logic d, input logic [W-1:0] p);
        if (c) begin
            mq = 0; mshifts = 0; mwv = 0;
        end else if (!e || m == 2'd0) begin
            mwv = 0;
        end else if (m == 2'd3) begin
            mq = int'(p); mshifts = 0; mwv = 0;
        end else begin
            if (m == 2'd1) mq = (mq / 2) + (int'(d) * (1 << (W - 1)));
            else           mq = ((mq * 2) + int'(d)) % (1 << W);
            mshifts++;
            mwv = (mshifts % W == 0) ? 1 : 0;
        end
    endtask

    function automatic int modelSerial(input logic [1:0] m);
        if (m == 2'd2) return (mq >> (W - 1)) & 1;
        return mq & 1;
    endfunction

    initial begin
        reset = 1'b1;
        setInputs(1'b0, 1'b1, 2'b11, 1'b0, 4'hF);

        // Reset held across an edge with load configured: everything stays zero
        @(posedge clk);
        #1;
        checkOutput("reset_salida", salida, 4'h0);
        checkOutput("reset_wv", word_valid, 1'b0);
        checkOutput("reset_serial", serial_out, 1'b0);
`ifdef REG_SHIFT_PARITY_EN
        checkOutput("reset_parity", parity, 1'b0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("load_after_reset", salida, 4'hF);

        // Asynchronous assertion between edges clears immediately
        reset = 1'b1;
        #1;
        checkOutput("async_reset_salida", salida, 4'h0);
        checkOutput("async_reset_wv", word_valid, 1'b0);
        #1;
        reset = 1'b0;
        setInputs(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
        @(posedge clk);
        #1;

        // Directed vectors: exp_so sampled before the edge, exp_q/exp_wv after
        vecs[0]  = '{1'b1, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b0, 4'b0100, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1010, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1101, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b1, 4'b1101, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 1'b0, 4'b1001, 1'b1, 4'b1001, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 1'b0, 4'h0, 1'b1, 4'b0010, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 4'h0, 1'b0, 4'b0100, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 4'h0, 1'b0, 4'b1000, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b10, 1'b0, 4'h0, 1'b1, 4'b0000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1000, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1100, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'b01, 1'b0, 4'h0, 1'b0, 4'b1100, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 2'b01, 1'b0, 4'h0, 1'b0, 4'b1100, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'b10, 1'b1, 4'h0, 1'b1, 4'b1100, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b0, 4'b0110, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1011, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 4'b0101, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 2'b10, 1'b1, 4'h0, 1'b0, 4'b1011, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 4'b0101, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 2'b01, 1'b1, 4'h0, 1'b1, 4'b0000, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1000, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1100, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1110, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b0, 4'b1111, 1'b1};
        vecs[26] = '{1'b0, 1'b1, 2'b11, 1'b0, 4'b0111, 1'b1, 4'b0111, 1'b0};
        vecs[27] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'h0, 1'b1, 4'b1011, 1'b0};

        for (int i = 0; i < 28; i++) begin
            setInputs(vecs[i].clr, vecs[i].en, vecs[i].m, vecs[i].d, vecs[i].p);
            checkOutput($sformatf("vec%0d_serial", i), serial_out, vecs[i].exp_so);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_salida", i), salida, vecs[i].exp_q);
            checkOutput($sformatf("vec%0d_wv", i), word_valid, vecs[i].exp_wv);
`ifdef REG_SHIFT_PARITY_EN
            checkOutput($sformatf("vec%0d_parity", i), parity, ^vecs[i].exp_q);
`endif
        end

        // Reset mid-word discards the partial word: four fresh shifts are needed
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 4'h0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 4'h0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midword_reset_salida", salida, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 4'h0);
            checkOutput($sformatf("midword_shift%0d_wv", i), word_valid, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 4'h0);
        checkOutput("midword_final_wv", word_valid, 1'b1);
        checkOutput("midword_final_salida", salida, 4'hF);

        // Random phase from a clean state against the reference model
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
        mq = 0; mshifts = 0; mwv = 0;
        for (int i = 0; i < 400; i++) begin
            logic         c, e, d;
            logic [1:0]   m;
            logic [W-1:0] p;
            c = ($urandom_range(0, 31) == 0);
            e = ($urandom_range(0, 7) != 0);
            m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            d = 1'($urandom);
            p = W'($urandom);
            setInputs(c, e, m, d, p);
            checkOutput($sformatf("rand%0d_serial", i), serial_out, 32'(modelSerial(m)));
            modelStep(c, e, m, d, p);
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d_salida", i), salida, 32'(mq));
            checkOutput($sformatf("rand%0d_wv", i), word_valid, 32'(mwv));
`ifdef REG_SHIFT_PARITY_EN
            checkOutput($sformatf("rand%0d_parity", i), parity, 32'($countones(mq) % 2));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
